// File: rtl/gcd_sweep_sequencer.sv
// rtl/gcd_sweep_sequencer.sv - operand-grid sweep driver for the ee354_GCD core
// Walks A_MIN..A_MAX x B_MIN..B_MAX (B innermost) and reports each result over valid/ready.
module gcd_sweep_sequencer #(
   parameter int W       = 8,
   parameter int A_MIN   = 2,
   parameter int A_MAX   = 63,
   parameter int B_MIN   = 2,
   parameter int B_MAX   = 63,
   parameter int TIMEOUT = 1023
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         CEN,
   input  logic         Go,
   output logic [W-1:0] Ain,
   output logic [W-1:0] Bin,
   output logic         Start,
   output logic         Ack,
   input  logic         q_Sub,
   input  logic         q_Done,
   input  logic [W-1:0] AB_GCD,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_A,
   output logic [W-1:0] res_B,
   output logic [W-1:0] res_GCD,
   output logic [15:0]  res_cycles,
   output logic [15:0]  pair_count,
   output logic         sweep_done,
   output logic         err
);
   localparam logic [W-1:0] A_MIN_C   = W'(A_MIN);
   localparam logic [W-1:0] A_MAX_C   = W'(A_MAX);
   localparam logic [W-1:0] B_MIN_C   = W'(B_MIN);
   localparam logic [W-1:0] B_MAX_C   = W'(B_MAX);
   localparam logic [15:0]  TIMEOUT_C = 16'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, START, WAIT_SUB, WAIT_DONE, ACK, EMIT, FIN, ERR
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] ain_q, ain_d, bin_q, bin_d;
   logic [W-1:0] res_a_q, res_a_d, res_b_q, res_b_d, res_gcd_q, res_gcd_d;
   logic [15:0]  cyc_q, cyc_d, res_cycles_q, res_cycles_d, pair_count_q, pair_count_d;
   logic         start_q, start_d, ack_q, ack_d, res_valid_q, res_valid_d;
   logic         sweep_done_q, sweep_done_d, err_q, err_d;

   always_comb begin
      state_d      = state_q;
      ain_d        = ain_q;
      bin_d        = bin_q;
      res_a_d      = res_a_q;
      res_b_d      = res_b_q;
      res_gcd_d    = res_gcd_q;
      res_cycles_d = res_cycles_q;
      cyc_d        = cyc_q;
      pair_count_d = pair_count_q;

      case (state_q)
         IDLE: begin
            if (Go) begin
               ain_d        = A_MIN_C;
               bin_d        = B_MIN_C;
               pair_count_d = '0;
               state_d      = START;
            end
         end
         START: state_d = WAIT_SUB;
         WAIT_SUB: begin
            // A core that reaches Done without a visible Sub phase reports zero cycles
            if (q_Done || q_Sub) begin
               cyc_d   = '0;
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (q_Done) begin
               res_a_d      = ain_q;
               res_b_d      = bin_q;
               res_gcd_d    = AB_GCD;
               res_cycles_d = cyc_q;
               state_d      = ACK;
            end else if (cyc_q == TIMEOUT_C) begin
               state_d = ERR;
            end else if (cyc_q != 16'hFFFF) begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         ACK: state_d = EMIT;
         EMIT: begin
            if (res_ready) begin
               pair_count_d = pair_count_q + 16'd1;
               // Limits are checked before incrementing so a MAX of 2^W-1 never wraps
               if (bin_q == B_MAX_C && ain_q == A_MAX_C) begin
                  state_d = FIN;
               end else if (bin_q == B_MAX_C) begin
                  ain_d   = ain_q + {{(W-1){1'b0}}, 1'b1};
                  bin_d   = B_MIN_C;
                  state_d = START;
               end else begin
                  bin_d   = bin_q + {{(W-1){1'b0}}, 1'b1};
                  state_d = START;
               end
            end
         end
         FIN: begin
            if (!Go) state_d = IDLE;
         end
         ERR: state_d = ERR;
         default: state_d = IDLE;
      endcase

      start_d      = (state_d == START);
      ack_d        = (state_d == ACK);
      res_valid_d  = (state_d == EMIT);
      sweep_done_d = (state_d == FIN);
      err_d        = (state_d == ERR);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         ain_q        <= '0;
         bin_q        <= '0;
         res_a_q      <= '0;
         res_b_q      <= '0;
         res_gcd_q    <= '0;
         res_cycles_q <= '0;
         cyc_q        <= '0;
         pair_count_q <= '0;
         start_q      <= 1'b0;
         ack_q        <= 1'b0;
         res_valid_q  <= 1'b0;
         sweep_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else if (CEN) begin
         state_q      <= state_d;
         ain_q        <= ain_d;
         bin_q        <= bin_d;
         res_a_q      <= res_a_d;
         res_b_q      <= res_b_d;
         res_gcd_q    <= res_gcd_d;
         res_cycles_q <= res_cycles_d;
         cyc_q        <= cyc_d;
         pair_count_q <= pair_count_d;
         start_q      <= start_d;
         ack_q        <= ack_d;
         res_valid_q  <= res_valid_d;
         sweep_done_q <= sweep_done_d;
         err_q        <= err_d;
      end
   end

   assign Ain        = ain_q;
   assign Bin        = bin_q;
   assign Start      = start_q;
   assign Ack        = ack_q;
   assign res_valid  = res_valid_q;
   assign res_A      = res_a_q;
   assign res_B      = res_b_q;
   assign res_GCD    = res_gcd_q;
   assign res_cycles = res_cycles_q;
   assign pair_count = pair_count_q;
   assign sweep_done = sweep_done_q;
   assign err        = err_q;
endmodule
